hilo_muldiv: RTL and testbench

- HILO register file plus multi-cycle multiply/divide engine for the MIPS core.
- Sits opposite the ALU's HILO interface. It supplies the current HI/LO values that the ALU reads for MFHI/MFLO, and accepts the ALU's MTHI/MTLO writes.
- Executes MULT/MULTU/DIV/DIVU and commits the 64-bit result into HI/LO.
- Drives a busy flag that the hazard unit uses to stall the pipeline.

---
 rtl/hilo_muldiv.sv | 191 +++++++++++++++++++
 tb/tb_hilo_muldiv.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// HILO register pair with a multi-cycle multiply/divide engine.
// MUL commits one edge after launch; DIV runs 32 restoring iterations, then commits.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic [WIDTH-1:0] lo_wdata,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               sgn_q, sgn_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] ext_a_s, ext_b_s, prod_s;
  logic [WIDTH:0]     rem_shift_s, diff_s;
  logic               q_bit_s;
  logic [WIDTH-1:0]   rem_next_s, quo_next_s, rem_fix_s, quo_fix_s;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; flush forces IDLE ahead of start or commit
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_d = md_op[1] ? S_DIV : S_MUL;
          else       state_d = S_IDLE;
        end
        S_MUL:   state_d = S_IDLE;
        S_DIV: begin
          if (cnt_q == 5'd31) state_d = S_IDLE;
          else                state_d = S_DIV;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign done   = done_q;

  // Arithmetic: full-width product and one restoring division step
  always_comb begin
    ext_a_s     = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
    ext_b_s     = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
    prod_s      = ext_a_s * ext_b_s;
    rem_shift_s = {rem_q, quo_q[WIDTH-1]};
    diff_s      = rem_shift_s - {1'b0, dvs_q};
    q_bit_s     = ~diff_s[WIDTH];
    rem_next_s  = q_bit_s ? diff_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
    quo_next_s  = {quo_q[WIDTH-2:0], q_bit_s};
    quo_fix_s   = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? ({WIDTH{1'b0}} - quo_next_s) : quo_next_s;
    rem_fix_s   = (sgn_q && a_q[WIDTH-1]) ? ({WIDTH{1'b0}} - rem_next_s) : rem_next_s;
  end

  // Datapath next values: operand latch, iteration, HI/LO writes and commit
  always_comb begin
    sgn_d  = sgn_q;
    a_d    = a_q;
    b_d    = b_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    if (!flush) begin
      case (state_q)
        S_IDLE: begin
          if (hi_we) hi_d = hi_wdata;
          else       hi_d = hi_q;
          if (lo_we) lo_d = lo_wdata;
          else       lo_d = lo_q;
          if (start) begin
            sgn_d = ~md_op[0];
            a_d   = a;
            b_d   = b;
            rem_d = {WIDTH{1'b0}};
            quo_d = magnitude(a, ~md_op[0]);
            dvs_d = magnitude(b, ~md_op[0]);
            cnt_d = 5'd0;
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_MUL: begin
          hi_d   = prod_s[2*WIDTH-1:WIDTH];
          lo_d   = prod_s[WIDTH-1:0];
          done_d = 1'b1;
        end
        S_DIV: begin
          rem_d = rem_next_s;
          quo_d = quo_next_s;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            // Divide by zero bypasses the sign fixup: LO all ones, HI the raw dividend
            if (b_q == {WIDTH{1'b0}}) begin
              lo_d = {WIDTH{1'b1}};
              hi_d = a_q;
            end else begin
              lo_d = quo_fix_s;
              hi_d = rem_fix_s;
            end
            done_d = 1'b1;
          end else begin
            done_d = 1'b0;
          end
        end
        default: begin
          done_d = 1'b0;
        end
      endcase
    end else begin
      done_d = 1'b0;
    end
  end

  // Datapath and HI/LO registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sgn_q  <= 1'b0;
      a_q    <= {WIDTH{1'b0}};
      b_q    <= {WIDTH{1'b0}};
      rem_q  <= {WIDTH{1'b0}};
      quo_q  <= {WIDTH{1'b0}};
      dvs_q  <= {WIDTH{1'b0}};
      cnt_q  <= 5'd0;
      hi_q   <= {WIDTH{1'b0}};
      lo_q   <= {WIDTH{1'b0}};
      done_q <= 1'b0;
    end else begin
      sgn_q  <= sgn_d;
      a_q    <= a_d;
      b_q    <= b_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: stimulus queues expected HI/LO, a monitor checks on done.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        resetn;
  logic        hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] a, b;
  logic        flush;
  logic [31:0] hi_out, lo_out;
  logic        busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  string       name_q[$];

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .start(start), .md_op(md_op), .a(a), .b(b), .flush(flush),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (resetn === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 with nothing expected, hi=%h lo=%h", hi_out, lo_out);
      end else begin
        chk(name_q.pop_front(), {hi_out, lo_out}, exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [63:0] expv,
                        input int exp_cyc, input bit poke);
    int cyc;
    logic [31:0] hold;
    start = 1'b1; md_op = op; a = av; b = bv;
    exp_q.push_back(expv);
    name_q.push_back(nm);
    tick();
    start = 1'b0; a = 32'h0; b = 32'h0;
    cyc = 0;
    hold = hi_out;
    while (busy && cyc < 100) begin
      if (poke && cyc == 3) begin
        start = 1'b1; md_op = 2'b01; a = 32'h7; b = 32'h9;
        hi_we = 1'b1; hi_wdata = 32'h5555_5555;
      end
      tick();
      if (poke && cyc == 3) begin
        start = 1'b0; hi_we = 1'b0;
        chk({nm, "_we_while_busy"}, {32'h0, hi_out}, {32'h0, hold});
      end
      cyc++;
    end
    chk({nm, "_busy_cycles"}, 64'(cyc), 64'(exp_cyc));
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; hi_we = 1'b0; lo_we = 1'b0; hi_wdata = 32'h0; lo_wdata = 32'h0;
    start = 1'b0; md_op = 2'b00; a = 32'h0; b = 32'h0; flush = 1'b0;
    #12;
    chk("reset_state", {hi_out, lo_out}, 64'h0);
    chk("reset_busy_done", {62'h0, busy, done}, 64'h0);
    tick();
    resetn = 1'b1;
    tick();

    // MTHI in IDLE
    hi_we = 1'b1; hi_wdata = 32'hDEAD_BEEF;
    tick();
    hi_we = 1'b0;
    chk("mthi", {32'h0, hi_out}, {32'h0, 32'hDEAD_BEEF});

    run_op("mult_neg3x5",   2'b00, 32'hFFFF_FFFD, 32'h5,         64'hFFFF_FFFF_FFFF_FFF1, 1,  1'b0);
    run_op("multu_max_x2",  2'b01, 32'hFFFF_FFFF, 32'h2,         64'h0000_0001_FFFF_FFFE, 1,  1'b0);

    // MTLO on the launch edge applies, then the product overwrites it
    start = 1'b1; md_op = 2'b01; a = 32'h3; b = 32'h4;
    lo_we = 1'b1; lo_wdata = 32'hAAAA_AAAA;
    exp_q.push_back(64'h0000_0000_0000_000C);
    name_q.push_back("mtlo_with_start_result");
    tick();
    start = 1'b0; lo_we = 1'b0;
    chk("mtlo_with_start_write", {31'h0, busy, lo_out}, {31'h0, 1'b1, 32'hAAAA_AAAA});
    tick();
    tick();

    run_op("div_neg7_by_2", 2'b10, 32'hFFFF_FFF9, 32'h2,         64'hFFFF_FFFF_FFFF_FFFD, 32, 1'b0);
    run_op("div_7_by_neg2", 2'b10, 32'h7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 32, 1'b0);
    run_op("divu_100_by_7", 2'b11, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 32, 1'b1);
    run_op("div_by_zero",   2'b10, 32'h1234_5678, 32'h0,         64'h1234_5678_FFFF_FFFF, 32, 1'b0);
    run_op("div_overflow",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 32, 1'b0);

    // Flush mid-DIV: no result, HI/LO preserved, writes on the flush edge blocked
    hi_we = 1'b1; hi_wdata = 32'h1111_2222; lo_we = 1'b1; lo_wdata = 32'h3333_4444;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    start = 1'b1; md_op = 2'b10; a = 32'd100; b = 32'd3;
    tick();
    start = 1'b0;
    repeat (4) tick();
    flush = 1'b1; hi_we = 1'b1; hi_wdata = 32'h9999_9999;
    tick();
    flush = 1'b0; hi_we = 1'b0;
    chk("flush_busy", {63'h0, busy}, 64'h0);
    repeat (40) tick();
    chk("flush_hilo_kept", {hi_out, lo_out}, 64'h1111_2222_3333_4444);

    // Flush beats start on the same edge
    start = 1'b1; flush = 1'b1; md_op = 2'b00; a = 32'h2; b = 32'h2;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_beats_start", {63'h0, busy}, 64'h0);
    repeat (3) tick();

    // Asynchronous reset at DIV iteration 10
    start = 1'b1; md_op = 2'b11; a = 32'd1000; b = 32'd9;
    tick();
    start = 1'b0;
    repeat (10) tick();
    resetn = 1'b0;
    #1;
    chk("async_reset_hilo", {hi_out, lo_out}, 64'h0);
    chk("async_reset_busy", {63'h0, busy}, 64'h0);
    tick();
    tick();
    resetn = 1'b1;
    repeat (40) tick();
    chk("post_reset_idle", {62'h0, busy, done}, 64'h0);

    chk("pending_results", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
